// File: rtl/serial_slave_port.sv
`default_nettype none
// ============================================================================
// serial_slave_port : bit-serial bus slave with a local memory; receives
// address/write data MSB first and serializes read data back on rd_bus.
// Optional macro: SERIAL_SLAVE_TIMEOUT_EN (abandon stalled transfers).
// Revision: 1.0
// ============================================================================
module serial_slave_port #(
  parameter int ADDR_WIDTH     = 12,
  parameter int DATA_WIDTH     = 8,
  parameter int TIMEOUT_CYCLES = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic mode,
  input  logic wr_bus,
  input  logic master_valid,
  input  logic master_ready,
  output logic rd_bus,
  output logic slave_ready,
  output logic slave_valid
);

  localparam int CNT_MAX = (ADDR_WIDTH > DATA_WIDTH) ? ADDR_WIDTH : DATA_WIDTH;
  localparam int CW      = $clog2(CNT_MAX);

  typedef enum logic [2:0] {
    S_IDLE, S_RX_ADDR, S_RX_DATA, S_WRITE, S_READ_WAIT, S_TX_DATA
  } state_e;

  state_e                  state_q, state_d;
  logic [CW-1:0]           count_q, count_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [DATA_WIDTH-1:0]   data_q, data_d;
  logic [DATA_WIDTH-1:0]   shift_q, shift_d;
  logic                    mode_q, mode_d;
  logic [DATA_WIDTH-1:0]   mem_q [2**ADDR_WIDTH];

  logic w_rx_hs;
  logic w_tx_hs;
  logic w_timeout;

  assign slave_ready = (state_q == S_IDLE) || (state_q == S_RX_ADDR) || (state_q == S_RX_DATA);
  assign slave_valid = (state_q == S_TX_DATA);
  assign rd_bus      = slave_valid & shift_q[DATA_WIDTH-1];
  assign w_rx_hs     = master_valid & slave_ready;
  assign w_tx_hs     = slave_valid & master_ready;

  // A zero timeout is meaningless; outside the optional feature the limit is otherwise unused.
  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
  end

`ifdef SERIAL_SLAVE_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] idle_q, idle_d;
  logic          w_active;

  assign w_active  = (state_q == S_RX_ADDR) || (state_q == S_RX_DATA) || (state_q == S_TX_DATA);
  assign w_timeout = w_active && (idle_q == TW'(TIMEOUT_CYCLES));

  always_comb begin
    idle_d = '0;
    if (w_active && (state_d != S_IDLE) && !(w_rx_hs || w_tx_hs)) begin
      idle_d = idle_q + TW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idle_q <= '0;
    end else begin
      idle_q <= idle_d;
    end
  end
`else
  assign w_timeout = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    addr_d  = addr_q;
    data_d  = data_q;
    shift_d = shift_q;
    mode_d  = mode_q;
    case (state_q)
      S_IDLE: begin
        if (w_rx_hs) begin
          mode_d  = mode;
          // Shifting in MSB first leaves every bit in its final position once the address completes.
          addr_d  = {addr_q[ADDR_WIDTH-2:0], wr_bus};
          count_d = CW'(1);
          state_d = S_RX_ADDR;
        end
      end
      S_RX_ADDR: begin
        if (w_rx_hs) begin
          addr_d = {addr_q[ADDR_WIDTH-2:0], wr_bus};
          if (count_q == CW'(ADDR_WIDTH - 1)) begin
            count_d = '0;
            state_d = mode_q ? S_RX_DATA : S_READ_WAIT;
          end else begin
            count_d = count_q + CW'(1);
          end
        end
      end
      S_RX_DATA: begin
        if (w_rx_hs) begin
          data_d = {data_q[DATA_WIDTH-2:0], wr_bus};
          if (count_q == CW'(DATA_WIDTH - 1)) begin
            count_d = '0;
            state_d = S_WRITE;
          end else begin
            count_d = count_q + CW'(1);
          end
        end
      end
      S_WRITE: begin
        state_d = S_IDLE;
      end
      S_READ_WAIT: begin
        shift_d = mem_q[addr_q];
        count_d = '0;
        state_d = S_TX_DATA;
      end
      S_TX_DATA: begin
        if (w_tx_hs) begin
          shift_d = {shift_q[DATA_WIDTH-2:0], 1'b0};
          if (count_q == CW'(DATA_WIDTH - 1)) begin
            count_d = '0;
            state_d = S_IDLE;
          end else begin
            count_d = count_q + CW'(1);
          end
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    if (w_timeout) begin
      state_d = S_IDLE;
      count_d = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      count_q <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      shift_q <= '0;
      mode_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      shift_q <= shift_d;
      mode_q  <= mode_d;
    end
  end

  // Memory contents survive reset.
  always_ff @(posedge clk) begin
    if (state_q == S_WRITE) begin
      mem_q[addr_q] <= data_q;
    end
  end

endmodule
`default_nettype wire
